skip_concat: RTL and testbench
==============================

SKIP_CONCAT -- requirements
Module: skip_concat

Interface
REQ-001 Parameter H, default 32, feature-map height, shared by the upsampled and skip maps.
REQ-002 Parameter W, default 32, feature-map width.
REQ-003 Parameter UP_CH, default 512, upsampled channels taken from the transpose-conv stage.
REQ-004 Parameter SKIP_CH, default 512, encoder skip channels.
REQ-005 Parameter DATA_WIDTH, default 16, Q8.8 sample width; data passes through unchanged.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse, honoured only in IDLE.
REQ-010 skip_in  in  DATA_WIDTH  encoder skip sample, channel-major (ch, row, col).
REQ-011 skip_valid / skip_ready  in / out  1 each  skip stream handshake.
REQ-012 up_in  in  DATA_WIDTH  upsampled sample, channel-major.
REQ-013 up_valid / up_ready  in / out  1 each  upsampled stream handshake.
REQ-014 feature_out  out  DATA_WIDTH  concatenated sample.
REQ-015 feature_valid_out  out  1  feature_out is valid.
REQ-016 out_ready  in  1  downstream accepts this cycle.
REQ-017 concat_done  out  1  high in DONE.

Function
REQ-018 Transfers shall occur only on cycles where valid and ready are both high; outputs shall hold stable while feature_valid_out=1 and out_ready=0.
REQ-019 FSM states: IDLE, LOAD_SKIP, PASS_UP, DRAIN_SKIP, DONE.
REQ-020 IDLE→LOAD_SKIP on start; all counters shall clear.
REQ-021 LOAD_SKIP: skip_ready=1 and up_ready=0; each transfer writes buffer[count]; after H*W*SKIP_CH transfers → PASS_UP.
REQ-022 PASS_UP: up_ready = !feature_valid_out || out_ready; each accepted up_in shall appear on feature_out the next cycle (1-cycle latency, registered); after H*W*UP_CH accepts → DRAIN_SKIP.
REQ-023 DRAIN_SKIP: buffer words shall be emitted in write order; synchronous-read RAM with one-word prefetch so streaming runs at 1 word/cycle under continuous out_ready.
REQ-024 Output order shall be all UP_CH channels, then all SKIP_CH channels (concat channel index c<UP_CH from up, else skip).
REQ-025 After the last skip word is accepted downstream → DONE; concat_done=1, feature_valid_out=0; DONE→IDLE on start (new frame begins LOAD_SKIP).
REQ-026 skip_ready=0 outside LOAD_SKIP; up_ready=0 outside PASS_UP; extra input beats are not consumed.
REQ-027 start outside IDLE/DONE shall be ignored.
REQ-028 Counters shall be sized $clog2(total+1); no wrap within a frame.
REQ-029 No valid cycle shall be lost or duplicated across the PASS_UP→DRAIN_SKIP boundary under any out_ready pattern.

Reset
REQ-030 On rst: state=IDLE; feature_out=0; feature_valid_out=0; concat_done=0; skip_ready=0; up_ready=0; counters=0.
REQ-031 Reset mid-frame shall abort immediately; buffer contents are don't-care; the next start restarts from LOAD_SKIP.

Structure
REQ-032 Shared package: DATA_WIDTH, FRAC_WIDTH=8, and the decoder-stage dimension constants.
REQ-033 One sub-module: skip_buffer_ram (single-port write, synchronous read, depth H*W*SKIP_CH).

Verification (H=W=2, UP_CH=2, SKIP_CH=1)
REQ-034 Reset then start; skip 0x0101..0x0104; up 0x0201..0x0208; out_ready=1 → output 0x0201..0x0208 then 0x0101..0x0104; 12 valid beats; concat_done high the cycle after the last.
REQ-035 Same frame with out_ready toggling 1,0,1,0 → identical 12-word sequence; feature_out stable during every stall.
REQ-036 up_valid asserted during LOAD_SKIP → up_ready stays 0 until the 4th skip beat completes.
REQ-037 Assert rst after 5 up beats, then start and send a fresh frame → only the fresh 12-word frame is output; no stale words.
REQ-038 start pulsed in PASS_UP → ignored; the sequence is unchanged.
REQ-039 Second frame after DONE with skip 0x0AAA×4 → the tail is four 0x0AAA words.

Source files
------------

// File: rtl/skip_concat_pkg.sv
// Shared decoder-stage constants and the skip_concat state encoding.
// Q8.8 samples pass through untouched; FRAC_WIDTH documents the format only.
package skip_concat_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int FRAC_WIDTH  = 8;

    localparam int DEC_H       = 32;
    localparam int DEC_W       = 32;
    localparam int DEC_UP_CH   = 512;
    localparam int DEC_SKIP_CH = 512;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_SKIP,
        PASS_UP,
        DRAIN_SKIP,
        DONE
    } state_t;

endpackage

// File: rtl/skip_concat_if.sv
// Stream bundle for skip_concat: skip and upsampled inputs, concatenated output.
// master = producer/consumer side (bench or neighbours), slave = skip_concat.
interface skip_concat_if #(
    parameter int DATA_WIDTH = skip_concat_pkg::DATA_WIDTH
);
    logic                  start;
    logic [DATA_WIDTH-1:0] skip_in;
    logic                  skip_valid;
    logic                  skip_ready;
    logic [DATA_WIDTH-1:0] up_in;
    logic                  up_valid;
    logic                  up_ready;
    logic [DATA_WIDTH-1:0] feature_out;
    logic                  feature_valid_out;
    logic                  out_ready;
    logic                  concat_done;

    modport master (
        output start, skip_in, skip_valid, up_in, up_valid, out_ready,
        input  skip_ready, up_ready, feature_out, feature_valid_out, concat_done
    );

    modport slave (
        input  start, skip_in, skip_valid, up_in, up_valid, out_ready,
        output skip_ready, up_ready, feature_out, feature_valid_out, concat_done
    );
endinterface

// File: rtl/skip_concat_skip_buffer_ram.sv
// Skip-map frame buffer: one write port, one registered read port.
// Read data appears one cycle after rd_en and holds until the next rd_en; no backpressure.
module skip_buffer_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int AW         = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/skip_concat.sv
// Channel concat: buffers the skip map, streams the up map through a 1-cycle register, then drains the skip map.
// Output register stalls on out_ready=0; input readies drop whenever the output register cannot advance.
module skip_concat
    import skip_concat_pkg::*;
#(
    parameter int H          = DEC_H,
    parameter int W          = DEC_W,
    parameter int UP_CH      = DEC_UP_CH,
    parameter int SKIP_CH    = DEC_SKIP_CH,
    parameter int DATA_WIDTH = skip_concat_pkg::DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    skip_concat_if.slave  bus
);

    localparam int SKIP_TOTAL = H * W * SKIP_CH;
    localparam int UP_TOTAL   = H * W * UP_CH;
    localparam int SCW        = $clog2(SKIP_TOTAL + 1);
    localparam int UCW        = $clog2(UP_TOTAL + 1);
    localparam int AW         = (SKIP_TOTAL > 1) ? $clog2(SKIP_TOTAL) : 1;

    localparam logic [SCW-1:0] SKIP_LAST = SCW'(SKIP_TOTAL - 1);
    localparam logic [SCW-1:0] SKIP_END  = SCW'(SKIP_TOTAL);
    localparam logic [UCW-1:0] UP_LAST   = UCW'(UP_TOTAL - 1);

    state_t                state, state_nxt;
    logic [SCW-1:0]        wr_cnt, rd_cnt;
    logic [UCW-1:0]        up_cnt;
    logic                  rd_pend;
    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_dat;
    logic [DATA_WIDTH-1:0] ram_dout;

    logic skip_rdy, up_rdy, rd_en, out_adv, frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        skip_rdy    = 1'b0;
        up_rdy      = 1'b0;
        rd_en       = 1'b0;
        frame_start = 1'b0;
        out_adv     = !out_vld || bus.out_ready;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt   = LOAD_SKIP;
                    frame_start = 1'b1;
                end
            end
            LOAD_SKIP: begin
                skip_rdy = 1'b1;
                if (bus.skip_valid && wr_cnt == SKIP_LAST) begin
                    state_nxt = PASS_UP;
                end
            end
            PASS_UP: begin
                up_rdy = out_adv;
                if (bus.up_valid && out_adv && up_cnt == UP_LAST) begin
                    state_nxt = DRAIN_SKIP;
                end
            end
            DRAIN_SKIP: begin
                // Refill the RAM read register only when its word is consumed this cycle.
                rd_en = (rd_cnt != SKIP_END) && (!rd_pend || out_adv);
                if (rd_cnt == SKIP_END && !rd_pend && out_adv) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            up_cnt  <= '0;
            rd_pend <= 1'b0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            if (frame_start) begin
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                up_cnt  <= '0;
                rd_pend <= 1'b0;
            end
            if (skip_rdy && bus.skip_valid) begin
                wr_cnt <= wr_cnt + SCW'(1);
            end
            if (up_rdy && bus.up_valid) begin
                up_cnt <= up_cnt + UCW'(1);
            end
            if (rd_en) begin
                rd_cnt  <= rd_cnt + SCW'(1);
                rd_pend <= 1'b1;
            end else if (rd_pend && out_adv) begin
                rd_pend <= 1'b0;
            end
            if (up_rdy && bus.up_valid) begin
                out_dat <= bus.up_in;
                out_vld <= 1'b1;
            end else if (rd_pend && out_adv) begin
                out_dat <= ram_dout;
                out_vld <= 1'b1;
            end else if (bus.out_ready) begin
                out_vld <= 1'b0;
            end
        end
    end

    skip_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKIP_TOTAL),
        .AW         (AW)
    ) u_skip_buffer_ram (
        .clk     (clk),
        .wr_en   (skip_rdy && bus.skip_valid),
        .wr_addr (wr_cnt[AW-1:0]),
        .wr_dat  (bus.skip_in),
        .rd_en   (rd_en),
        .rd_addr (rd_cnt[AW-1:0]),
        .rd_dat  (ram_dout)
    );

    assign bus.skip_ready        = skip_rdy;
    assign bus.up_ready          = up_rdy;
    assign bus.feature_out       = out_dat;
    assign bus.feature_valid_out = out_vld;
    assign bus.concat_done       = (state == DONE);

endmodule

// File: tb/tb_skip_concat.sv
// Scoreboard bench for skip_concat on a 2x2 map with 2 up channels and 1 skip channel.
// Expected frames come from the concat channel rule; a negedge monitor pops and compares.
module tb_skip_concat;

    localparam int H = 2, W = 2, UP_CH = 2, SKIP_CH = 1, DW = 16;
    localparam int HW  = H * W;
    localparam int NUP = HW * UP_CH;
    localparam int NSK = HW * SKIP_CH;

    logic clk = 1'b0;
    logic rst;

    skip_concat_if #(.DATA_WIDTH(DW)) bus();

    skip_concat #(
        .H(H), .W(W), .UP_CH(UP_CH), .SKIP_CH(SKIP_CH), .DATA_WIDTH(DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pop_cyc = -10;
    int ready_mode = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] skw[NSK];
    logic [DW-1:0] upw[NUP];
    logic [DW-1:0] mon_exp;
    logic [DW-1:0] stall_dat;
    logic          stall_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Downstream readiness pattern: 0 always ready, 1 toggling, else random.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_vld", bus.feature_valid_out, 1);
                check("stall_hold_dat", bus.feature_out, stall_dat);
            end
            if (bus.feature_valid_out && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word actual=%h required=none", bus.feature_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("feature_out", bus.feature_out, mon_exp);
                    if (exp_q.size() == 0) last_pop_cyc = cyc;
                end
            end
            stall_prev = bus.feature_valid_out && !bus.out_ready;
            stall_dat  = bus.feature_out;
        end
    end

    task automatic check_reset_outputs();
        check("rst_vld",       bus.feature_valid_out, 0);
        check("rst_dat",       bus.feature_out, 0);
        check("rst_done",      bus.concat_done, 0);
        check("rst_skip_rdy",  bus.skip_ready, 0);
        check("rst_up_rdy",    bus.up_ready, 0);
    endtask

    // abort_at < 0: full frame; otherwise reset after abort_at up beats.
    task automatic run_frame(input int rmode, input bit early_up, input bit start_mid, input int abort_at);
        int si, ui, budget;
        bit up_in_load;
        ready_mode = (abort_at >= 0) ? 0 : rmode;
        for (int c = 0; c < UP_CH + SKIP_CH; c++) begin
            for (int p = 0; p < HW; p++) begin
                if (abort_at < 0 || (c < UP_CH && c * HW + p < abort_at))
                    exp_q.push_back((c < UP_CH) ? upw[c * HW + p] : skw[(c - UP_CH) * HW + p]);
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        si = 0; ui = 0; budget = 0; up_in_load = 1'b0;
        while ((si < NSK || ui < NUP) && !(abort_at >= 0 && ui >= abort_at) && budget < 2000) begin
            bus.skip_valid = (si < NSK) && ($urandom_range(0, 3) != 0);
            if (si < NSK) bus.skip_in = skw[si];
            bus.up_valid = (ui < NUP) && (early_up || si == NSK) && ($urandom_range(0, 3) != 0);
            if (ui < NUP) bus.up_in = upw[ui];
            bus.start = start_mid && (si == NSK) && (ui == 2);
            @(negedge clk);
            if (si < NSK && bus.up_ready) up_in_load = 1'b1;
            if (bus.skip_valid && bus.skip_ready) si++;
            if (bus.up_valid && bus.up_ready) ui++;
            @(posedge clk); #1;
            budget++;
        end
        bus.skip_valid = 1'b0;
        bus.up_valid   = 1'b0;
        bus.start      = 1'b0;
        check("input_budget", budget < 2000, 1);
        check("up_ready_in_load", up_in_load, 0);
        if (abort_at >= 0) begin
            repeat (3) @(posedge clk);
            #1;
            check("pre_abort_drained", exp_q.size(), 0);
            rst = 1'b1;
            @(negedge clk);
            check_reset_outputs();
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!bus.concat_done && budget < 500);
            check("done_seen",     bus.concat_done, 1);
            check("done_latency",  cyc, last_pop_cyc + 1);
            check("queue_empty",   exp_q.size(), 0);
            check("done_vld",      bus.feature_valid_out, 0);
            check("done_skip_rdy", bus.skip_ready, 0);
            check("done_up_rdy",   bus.up_ready, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NSK; i++) skw[i] = 16'($urandom);
        for (int i = 0; i < NUP; i++) upw[i] = 16'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.skip_valid = 1'b0;
        bus.skip_in = '0;
        bus.up_valid = 1'b0;
        bus.up_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NSK; i++) skw[i] = 16'h0101 + 16'(i);
        for (int i = 0; i < NUP; i++) upw[i] = 16'h0201 + 16'(i);
        run_frame(0, 1'b0, 1'b0, -1);
        run_frame(1, 1'b0, 1'b0, -1);
        run_frame(2, 1'b1, 1'b0, -1);
        run_frame(2, 1'b1, 1'b1, -1);

        for (int i = 0; i < NSK; i++) skw[i] = 16'h0AAA;
        run_frame(0, 1'b0, 1'b0, -1);

        fill_random();
        run_frame(0, 1'b1, 1'b0, 5);
        fill_random();
        run_frame(2, 1'b1, 1'b0, -1);

        for (int f = 0; f < 8; f++) begin
            fill_random();
            run_frame(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
